// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the phase-1 control path and ALU datapath:
//   - opcode encodings (common with the ALU op_code)
//   - instruction field bit positions. The immediate is instr[18:0] and is
//     driven onto the bus by the datapath when c_out is asserted.
//   - sequencer state encoding (IDLE, T1..T4)
//   - opcode sequencing classes
//   - the registered control-strobe bundle driven by alu_sequencer
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int OP_W    = 5;
  localparam int RS_W    = 4;
  localparam int INSTR_W = 32;

  // Instruction field positions
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;

  // Opcodes
  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b00101;
  localparam logic [OP_W-1:0] OP_SHRA = 5'b00110;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b00111;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b01000;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01001;
  localparam logic [OP_W-1:0] OP_AND  = 5'b01010;
  localparam logic [OP_W-1:0] OP_OR   = 5'b01011;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    CL_BINARY  = 3'd0,
    CL_IMM     = 3'd1,
    CL_UNARY   = 3'd2,
    CL_MULDIV  = 3'd3,
    CL_ILLEGAL = 3'd4
  } op_class_e;

  typedef struct packed {
    logic            done;
    logic            illegal;
    logic [OP_W-1:0] alu_op;
    logic            reg_out_en;
    logic [RS_W-1:0] reg_out_sel;
    logic            reg_in_en;
    logic [RS_W-1:0] reg_in_sel;
    logic            c_out;
    logic            y_in;
    logic            z_in;
    logic            zlo_out;
    logic            zhi_out;
    logic            lo_in;
    logic            hi_in;
  } ctrl_t;

endpackage

// File: rtl/op_classify.sv
// -----------------------------------------------------------------------------
// op_classify
// Combinational map from opcode to sequencing class.
// Optional feature macro: MULDIV_EN. When defined, mul/div classify as
// CL_MULDIV; otherwise they are CL_ILLEGAL.
// Ports:
//   op        in   OP_W  opcode field of the instruction
//   op_class  out  class (BINARY, IMM, UNARY, MULDIV, ILLEGAL)
// -----------------------------------------------------------------------------
module op_classify
  import cpu_pkg::*;
(
  input  logic [OP_W-1:0] op,
  output op_class_e       op_class
);

  // Opcode to class lookup; anything not listed is unsupported.
  always_comb begin
    op_class = CL_ILLEGAL;
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:          op_class = CL_BINARY;
      OP_ADDI, OP_ANDI, OP_ORI:               op_class = CL_IMM;
      OP_NEG, OP_NOT:                         op_class = CL_UNARY;
`ifdef MULDIV_EN
      OP_MUL, OP_DIV:                         op_class = CL_MULDIV;
`else
      OP_MUL, OP_DIV:                         op_class = CL_ILLEGAL;
`endif
      OP_LD, OP_LDI, OP_ST:                   op_class = CL_ILLEGAL;
      default:                                op_class = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
// Latches one instruction on start (in IDLE) and steps T1..T4, driving the
// register-file, Y, Z, HI/LO strobes and the ALU op_code so the ALU result
// lands in ra or in LO/HI.
// Optional feature macro: MULDIV_EN (4-step mul/div sequence into LO/HI).
// Without it mul/div are illegal and lo_in/hi_in/zhi_out stay 0.
// Ports:
//   clk, reset                 clock, async active-high reset
//   start, instr               request and instruction word (sampled in IDLE)
//   busy, done, illegal        status (done/illegal are one-cycle pulses)
//   alu_op                     ALU op_code (0 unless z_in)
//   reg_out_en/sel             GPR bus driver
//   reg_in_en/sel              GPR write strobe
//   c_out, y_in, z_in          immediate driver, Y load, Z load
//   zlo_out, zhi_out           Z[31:0] / Z[63:32] bus drivers
//   lo_in, hi_in               LO / HI loads
// All outputs are flops; they are pre-decoded from the next state and the
// next instruction-register value, so they never depend combinationally on
// start or instr.
// -----------------------------------------------------------------------------
module alu_sequencer
  import cpu_pkg::*;
#(
  parameter int OPW = OP_W,
  parameter int RSW = RS_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [INSTR_W-1:0] instr,
  output logic               busy,
  output logic               done,
  output logic               illegal,
  output logic [OPW-1:0]     alu_op,
  output logic               reg_out_en,
  output logic [RSW-1:0]     reg_out_sel,
  output logic               reg_in_en,
  output logic [RSW-1:0]     reg_in_sel,
  output logic               c_out,
  output logic               y_in,
  output logic               z_in,
  output logic               zlo_out,
  output logic               zhi_out,
  output logic               lo_in,
  output logic               hi_in
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic               busy_q, busy_d;
  op_class_e          cls_s;
  logic [RS_W-1:0]    ra_s, rb_s, rc_s;

  // Fields of the instruction that is (or is about to be) latched.
  assign ra_s = ir_d[RA_MSB:RA_LSB];
  assign rb_s = ir_d[RB_MSB:RB_LSB];
  assign rc_s = ir_d[RC_MSB:RC_LSB];

  op_classify u_op_classify (
    .op       (ir_d[OP_MSB:OP_LSB]),
    .op_class (cls_s)
  );

  // Next state and instruction register; start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      ST_IDLE: begin
        ir_d    = start ? instr : ir_q;
        state_d = start ? ST_T1 : ST_IDLE;
      end
      ST_T1:   state_d = (cls_s == CL_ILLEGAL) ? ST_IDLE : ST_T2;
      ST_T2:   state_d = (cls_s == CL_UNARY)   ? ST_IDLE : ST_T3;
      ST_T3:   state_d = (cls_s == CL_MULDIV)  ? ST_T4   : ST_IDLE;
      ST_T4:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobe decode for the state being entered. Exactly one bus driver per step.
  always_comb begin
    ctrl_d = '0;
    busy_d = (state_d != ST_IDLE);
    case (state_d)
      ST_T1: begin
        case (cls_s)
          CL_BINARY, CL_IMM: begin
            ctrl_d.reg_out_en  = 1'b1;
            ctrl_d.reg_out_sel = rb_s;
            ctrl_d.y_in        = 1'b1;
          end
          CL_UNARY: begin
            ctrl_d.reg_out_en  = 1'b1;
            ctrl_d.reg_out_sel = rb_s;
            ctrl_d.alu_op      = ir_d[OP_MSB:OP_LSB];
            ctrl_d.z_in        = 1'b1;
          end
`ifdef MULDIV_EN
          // Y takes ra so that the ALU computes ra OP rb.
          CL_MULDIV: begin
            ctrl_d.reg_out_en  = 1'b1;
            ctrl_d.reg_out_sel = ra_s;
            ctrl_d.y_in        = 1'b1;
          end
`endif
          default: ctrl_d.illegal = 1'b1;
        endcase
      end
      ST_T2: begin
        case (cls_s)
          CL_BINARY: begin
            ctrl_d.reg_out_en  = 1'b1;
            ctrl_d.reg_out_sel = rc_s;
            ctrl_d.alu_op      = ir_d[OP_MSB:OP_LSB];
            ctrl_d.z_in        = 1'b1;
          end
          CL_IMM: begin
            ctrl_d.c_out  = 1'b1;
            ctrl_d.alu_op = ir_d[OP_MSB:OP_LSB];
            ctrl_d.z_in   = 1'b1;
          end
          CL_UNARY: begin
            ctrl_d.zlo_out    = 1'b1;
            ctrl_d.reg_in_en  = 1'b1;
            ctrl_d.reg_in_sel = ra_s;
            ctrl_d.done       = 1'b1;
          end
`ifdef MULDIV_EN
          CL_MULDIV: begin
            ctrl_d.reg_out_en  = 1'b1;
            ctrl_d.reg_out_sel = rb_s;
            ctrl_d.alu_op      = ir_d[OP_MSB:OP_LSB];
            ctrl_d.z_in        = 1'b1;
          end
`endif
          default: ctrl_d = '0;
        endcase
      end
      ST_T3: begin
        case (cls_s)
          CL_BINARY, CL_IMM: begin
            ctrl_d.zlo_out    = 1'b1;
            ctrl_d.reg_in_en  = 1'b1;
            ctrl_d.reg_in_sel = ra_s;
            ctrl_d.done       = 1'b1;
          end
`ifdef MULDIV_EN
          CL_MULDIV: begin
            ctrl_d.zlo_out = 1'b1;
            ctrl_d.lo_in   = 1'b1;
          end
`endif
          default: ctrl_d = '0;
        endcase
      end
`ifdef MULDIV_EN
      ST_T4: begin
        ctrl_d.zhi_out = 1'b1;
        ctrl_d.hi_in   = 1'b1;
        ctrl_d.done    = 1'b1;
      end
`endif
      default: ctrl_d = '0;
    endcase
  end

  // Sequencer state, instruction register and registered strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      ctrl_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ctrl_q  <= ctrl_d;
      busy_q  <= busy_d;
    end
  end

  assign busy        = busy_q;
  assign done        = ctrl_q.done;
  assign illegal     = ctrl_q.illegal;
  assign alu_op      = ctrl_q.alu_op;
  assign reg_out_en  = ctrl_q.reg_out_en;
  assign reg_out_sel = ctrl_q.reg_out_sel;
  assign reg_in_en   = ctrl_q.reg_in_en;
  assign reg_in_sel  = ctrl_q.reg_in_sel;
  assign c_out       = ctrl_q.c_out;
  assign y_in        = ctrl_q.y_in;
  assign z_in        = ctrl_q.z_in;
  assign zlo_out     = ctrl_q.zlo_out;
  assign zhi_out     = ctrl_q.zhi_out;
  assign lo_in       = ctrl_q.lo_in;
  assign hi_in       = ctrl_q.hi_in;

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
// Directed stimulus for alu_sequencer. A reference model turns each accepted
// instruction into the list of per-cycle strobe patterns it must produce; a
// compare process checks every cycle against it (all-zero when idle or in
// reset). Literal checks at key points pin the model.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       illegal;
    logic [4:0] alu_op;
    logic       roe;
    logic [3:0] ros;
    logic       rie;
    logic [3:0] ris;
    logic       c_out;
    logic       y_in;
    logic       z_in;
    logic       zlo;
    logic       zhi;
    logic       lo;
    logic       hi;
  } obs_t;

`ifdef MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] instr;
  logic        busy, done, illegal, reg_out_en, reg_in_en;
  logic [4:0]  alu_op;
  logic [3:0]  reg_out_sel, reg_in_sel;
  logic        c_out, y_in, z_in, zlo_out, zhi_out, lo_in, hi_in;

  obs_t act;
  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  alu_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .instr       (instr),
    .busy        (busy),
    .done        (done),
    .illegal     (illegal),
    .alu_op      (alu_op),
    .reg_out_en  (reg_out_en),
    .reg_out_sel (reg_out_sel),
    .reg_in_en   (reg_in_en),
    .reg_in_sel  (reg_in_sel),
    .c_out       (c_out),
    .y_in        (y_in),
    .z_in        (z_in),
    .zlo_out     (zlo_out),
    .zhi_out     (zhi_out),
    .lo_in       (lo_in),
    .hi_in       (hi_in)
  );

  always #5 clk = ~clk;

  assign act = {busy, done, illegal, alu_op, reg_out_en, reg_out_sel,
                reg_in_en, reg_in_sel, c_out, y_in, z_in, zlo_out, zhi_out,
                lo_in, hi_in};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic [18:0] low);
    return {op, ra, rb, low};
  endfunction

  // Reference model: the full cycle-by-cycle trace of one instruction.
  task automatic push_seq(input logic [31:0] ins);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    obs_t e1, e2, e3, e4;
    op = ins[31:27];
    ra = ins[26:23];
    rb = ins[22:19];
    rc = ins[18:15];
    e1 = '0; e2 = '0; e3 = '0; e4 = '0;
    e1.busy = 1'b1; e2.busy = 1'b1; e3.busy = 1'b1; e4.busy = 1'b1;
    if ((op >= 5'd3 && op <= 5'd14)) begin
      // binary R-type and immediate: ra = rb OP (rc | imm)
      e1.roe = 1'b1; e1.ros = rb; e1.y_in = 1'b1;
      if (op >= 5'd12) e2.c_out = 1'b1;
      else begin e2.roe = 1'b1; e2.ros = rc; end
      e2.alu_op = op; e2.z_in = 1'b1;
      e3.zlo = 1'b1; e3.rie = 1'b1; e3.ris = ra; e3.done = 1'b1;
      exp_q.push_back(e1); exp_q.push_back(e2); exp_q.push_back(e3);
    end else if (op == 5'd17 || op == 5'd18) begin
      e1.roe = 1'b1; e1.ros = rb; e1.alu_op = op; e1.z_in = 1'b1;
      e2.zlo = 1'b1; e2.rie = 1'b1; e2.ris = ra; e2.done = 1'b1;
      exp_q.push_back(e1); exp_q.push_back(e2);
    end else if ((op == 5'd15 || op == 5'd16) && MULDIV) begin
      e1.roe = 1'b1; e1.ros = ra; e1.y_in = 1'b1;
      e2.roe = 1'b1; e2.ros = rb; e2.alu_op = op; e2.z_in = 1'b1;
      e3.zlo = 1'b1; e3.lo = 1'b1;
      e4.zhi = 1'b1; e4.hi = 1'b1; e4.done = 1'b1;
      exp_q.push_back(e1); exp_q.push_back(e2); exp_q.push_back(e3); exp_q.push_back(e4);
    end else begin
      e1.illegal = 1'b1;
      exp_q.push_back(e1);
    end
  endtask

  // Per-cycle compare against the model; accepts a new instruction only when idle.
  always @(negedge clk) begin
    obs_t e;
    bit   was_idle;
    if (reset) begin
      exp_q.delete();
      e = '0;
      chk("reset_outputs", act, e);
    end else begin
      was_idle = (exp_q.size() == 0);
      if (was_idle) e = '0;
      else e = exp_q.pop_front();
      chk("cycle", act, e);
      if (was_idle && start) push_seq(instr);
    end
  end

  task automatic issue(input logic [31:0] ins);
    @(posedge clk); #1 start = 1'b1; instr = ins;
    @(posedge clk); #1 start = 1'b0; instr = 32'hFFFF_FFFF;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; instr = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk); chk("reset_busy", {31'd0, busy}, 32'd0);
    #2 reset = 1'b0;
    @(negedge clk); chk("post_release_busy", {31'd0, busy}, 32'd0);

    // add r1,r2,r3
    issue(32'h18918000);
    @(negedge clk);
    chk("add_t1_sel", {28'd0, reg_out_sel}, 32'd2);
    chk("add_t1_yin", {31'd0, y_in}, 32'd1);
    @(negedge clk);
    chk("add_t2_sel", {28'd0, reg_out_sel}, 32'd3);
    chk("add_t2_op", {27'd0, alu_op}, 32'd3);
    chk("add_t2_zin", {31'd0, z_in}, 32'd1);
    @(negedge clk);
    chk("add_t3_zlo", {31'd0, zlo_out}, 32'd1);
    chk("add_t3_in_sel", {28'd0, reg_in_sel}, 32'd1);
    chk("add_t3_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    chk("add_after_busy", {31'd0, busy}, 32'd0);

    // not r4,r5
    issue(mk(5'b10010, 4'd4, 4'd5, 19'd0));
    @(negedge clk);
    chk("not_t1_sel", {28'd0, reg_out_sel}, 32'd5);
    chk("not_t1_op", {27'd0, alu_op}, 32'h12);
    chk("not_t1_zin", {31'd0, z_in}, 32'd1);
    @(negedge clk);
    chk("not_t2_in_sel", {28'd0, reg_in_sel}, 32'd4);
    chk("not_t2_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    chk("not_after_busy", {31'd0, busy}, 32'd0);

    // andi r6,r7,#0x7FFFF
    issue(mk(5'b01101, 4'd6, 4'd7, 19'h7FFFF));
    @(negedge clk);
    @(negedge clk);
    chk("andi_t2_cout", {31'd0, c_out}, 32'd1);
    chk("andi_t2_roe", {31'd0, reg_out_en}, 32'd0);
    @(negedge clk);
    chk("andi_t3_in_sel", {28'd0, reg_in_sel}, 32'd6);
    chk("andi_t3_done", {31'd0, done}, 32'd1);
    repeat (2) @(posedge clk);

    // mul r2,r3
    issue(mk(5'b01111, 4'd2, 4'd3, 19'd0));
`ifdef MULDIV_EN
    @(negedge clk);
    chk("mul_t1_sel", {28'd0, reg_out_sel}, 32'd2);
    @(negedge clk);
    @(negedge clk);
    chk("mul_t3_lo", {31'd0, lo_in}, 32'd1);
    @(negedge clk);
    chk("mul_t4_hi", {31'd0, hi_in}, 32'd1);
    chk("mul_t4_zhi", {31'd0, zhi_out}, 32'd1);
    chk("mul_t4_done", {31'd0, done}, 32'd1);
`else
    @(negedge clk);
    chk("mul_t1_illegal", {31'd0, illegal}, 32'd1);
    chk("mul_t1_yin", {31'd0, y_in}, 32'd0);
    chk("mul_t1_roe", {31'd0, reg_out_en}, 32'd0);
    chk("mul_t1_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("mul_after_busy", {31'd0, busy}, 32'd0);
`endif
    repeat (2) @(posedge clk);

    // Assorted opcodes checked by the model only
    issue(mk(5'b00100, 4'd15, 4'd0, {4'd9, 15'd0}));     // sub
    repeat (4) @(posedge clk);
    issue(mk(5'b01001, 4'd8, 4'd8, {4'd8, 15'h1234}));   // rol, ra=rb=rc
    repeat (4) @(posedge clk);
    issue(mk(5'b01110, 4'd3, 4'd12, 19'h40000));          // ori
    repeat (4) @(posedge clk);
    issue(mk(5'b10001, 4'd10, 4'd11, 19'd0));             // neg
    repeat (3) @(posedge clk);
    issue(mk(5'b10000, 4'd5, 4'd6, 19'd0));               // div
    repeat (5) @(posedge clk);
    issue(mk(5'b00000, 4'd1, 4'd1, 19'd0));               // ld
    repeat (2) @(posedge clk);
    issue(mk(5'b11111, 4'd7, 4'd7, 19'd0));               // undefined
    repeat (2) @(posedge clk);

    // Reset during T2 of add
    issue(32'h18918000);
    @(posedge clk); #1 reset = 1'b1;
    #1 chk("rst_mid_outputs", {7'd0, act}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); #2 reset = 1'b0;
    issue(32'h18918000);
    repeat (5) @(posedge clk);

    // start held high through an add; instr changes mid-sequence
    @(posedge clk); #1 start = 1'b1; instr = 32'h18918000;
    @(posedge clk);
    @(posedge clk); #1 instr = mk(5'b00100, 4'd9, 4'd10, {4'd11, 15'd0});
    @(posedge clk);
    @(negedge clk);
    chk("hold_t3_done", {31'd0, done}, 32'd1);
    chk("hold_t3_in_sel", {28'd0, reg_in_sel}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("hold_gap_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("hold_second_sel", {28'd0, reg_out_sel}, 32'd10);
    repeat (5) @(posedge clk);

    if (exp_q.size() != 0) chk("model_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Control-side initiator for the phase-1 ALU datapath. It latches one instruction word and steps through timing states T1..T4. In each state it drives register-file select and enable strobes, Y-in, the ALU op_code, Z-in and Z-out so that the 64-bit ALU result lands in the register file or in HI/LO. It sits between the instruction source (testbench for now, later the fetch logic) and the bus/ALU/Z datapath.

Parameters:
- OPW, 5, opcode width; matches the ALU op_code.
- RSW, 4, register-select width (16 GPRs).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- instr  in  32  fields: op=[31:27], ra=[26:23], rb=[22:19], rc=[18:15]; [18:0] also carries the immediate
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse in the final step of a sequence
- illegal  out  1  one-cycle pulse when the opcode is unsupported
- alu_op  out  OPW  op_code driven to the ALU
- reg_out_en  out  1  enables the selected GPR onto the bus
- reg_out_sel  out  RSW  GPR driven onto the bus
- reg_in_en  out  1  write strobe for the selected GPR
- reg_in_sel  out  RSW  GPR written from the bus
- c_out  out  1  drives the sign-extended instr[18:0] onto the bus
- y_in  out  1  loads Y from the bus
- z_in  out  1  loads the 64-bit Z register from the ALU c output
- zlo_out  out  1  drives Z[31:0] onto the bus
- zhi_out  out  1  drives Z[63:32] onto the bus
- lo_in  out  1  loads LO from the bus
- hi_in  out  1  loads HI from the bus

Behaviour:
- Reset: state=IDLE and the instruction register is cleared. Every output reads 0 while reset is high and on the first cycle after release. Reset mid-sequence aborts immediately with no partial strobes.
- All outputs are decoded from the state register and the latched instruction only. There is no combinational path from start or instr to any output.
- Start acceptance: in IDLE, start=1 latches instr, and the next state is T1. While busy, start is ignored and instr is not re-latched.
- Opcode classes and per-state strobes (exactly one bus driver per cycle):
  - Binary R-type (add, sub, shr, shra, shl, ror, rol, and, or):
    - T1: reg_out(rb), y_in.
    - T2: reg_out(rc), alu_op=op, z_in.
    - T3: zlo_out, reg_in(ra), done; then IDLE.
    - Operand order: ALU a comes from Y (rb), b from the bus (rc), so ra = rb OP rc.
  - Immediate (addi, andi, ori): as binary R-type, except T2 asserts c_out in place of reg_out.
  - Unary (neg, not):
    - T1: reg_out(rb), alu_op=op, z_in.
    - T2: zlo_out, reg_in(ra), done; then IDLE.
  - mul/div (see Optional Feature):
    - T1: reg_out(ra), y_in.
    - T2: reg_out(rb), alu_op=op, z_in.
    - T3: zlo_out, lo_in.
    - T4: zhi_out, hi_in, done; then IDLE.
  - Any other opcode (ld, ldi, st, 10011..11111):
    - T1: illegal=1 with no datapath strobes; then IDLE.
    - done is not asserted.
- alu_op is 0 in every state that does not assert z_in.
- Latency from the start edge to the done cycle: binary/immediate 3 cycles, unary 2, mul/div 4.
- Back-to-back operation: start is accepted on the first IDLE cycle after done, giving 1 idle cycle minimum between sequences.
- ra == rb == rc is legal and handled like any other instruction; no hazard logic is required.
- reg_out_sel and reg_in_sel are 0 whenever their enable is 0.

Optional Feature:
- MULDIV_EN defined: mul (01111) and div (10000) run the 4-step HI/LO sequence.
- MULDIV_EN undefined: mul and div fall into the illegal class (T1 illegal pulse), and lo_in/hi_in/zhi_out are tied to 0.

Decomposition:
- Shared package cpu_pkg holds:
  - the opcode localparams (ld=00000 … not=10010), common with the ALU;
  - the state encoding (IDLE, T1–T4);
  - the instr field bit positions.
- One combinational sub-module, op_classify: maps op to a class (BINARY, IMM, UNARY, MULDIV, ILLEGAL). It is instantiated once and reused by the fetch logic later.

Test Plan:
- Reset during T2 of add → all outputs 0 in the same cycle, busy=0; a new start of add r1,r2,r3 then completes normally.
- start with instr=0x18918000 (add ra=1, rb=2, rc=3):
  - T1: reg_out_sel=2, y_in=1.
  - T2: reg_out_sel=3, alu_op=00011, z_in=1.
  - T3: zlo_out=1, reg_in_sel=1, done=1.
  - Next cycle: busy=0.
- not ra=4, rb=5 → T1: reg_out_sel=5, alu_op=10010, z_in=1; T2: reg_in_sel=4, done=1. Total 2 busy cycles.
- andi ra=6, rb=7 → T2: c_out=1 and reg_out_en=0; T3: reg_in_sel=6, done=1.
- mul ra=2, rb=3:
  - With MULDIV_EN: T3 lo_in=1, T4 hi_in=1 and zhi_out=1, done=1.
  - Without MULDIV_EN: T1 illegal=1, no strobes, done=0.
- start held high through an entire add sequence with instr changing mid-sequence → only the first instr executes. A second start is accepted on the cycle after done.
